// File: rtl/logic_input_qualifier.sv
// logic_input_qualifier: hysteresis + settle-delay qualifier turning an ADC code into q/q_x with rise/fall pulses (clk, rst_n, sample, sample_valid -> q, q_x, rise, fall)
module logic_input_qualifier #(
  parameter int W = 8,
  parameter int THH = 230,
  parameter int THL = 26,
  parameter int DELAY = 4,
  parameter int X_TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] sample,
  input  logic         sample_valid,
  output logic         q,
  output logic         q_x,
  output logic         rise,
  output logic         fall
);
  localparam int CW = $clog2(X_TIMEOUT + 1);
  if (THL >= THH || DELAY < 1 || X_TIMEOUT <= DELAY) begin : g_param_check
    $error("logic_input_qualifier: invalid parameters");
  end
  typedef enum logic [1:0] {UNKNOWN, LOW, HIGH} state_t;
  state_t state;
  logic [CW-1:0] qual_cnt, mid_cnt, qual_inc, mid_inc, run_n;
  logic tgt, is_h, is_l, toward, hold;
  always_comb begin
    is_h = sample >= W'(THH);
    is_l = sample <= W'(THL);
    qual_inc = qual_cnt == CW'(X_TIMEOUT) ? qual_cnt : qual_cnt + 1'b1;
    mid_inc = mid_cnt == CW'(X_TIMEOUT) ? mid_cnt : mid_cnt + 1'b1;
    run_n = (qual_cnt != '0 && tgt == is_h) ? qual_inc : CW'(1);
    toward = state == LOW ? is_h : state == HIGH ? is_l : 1'b0;
    hold = state == LOW ? is_l : state == HIGH ? is_h : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= UNKNOWN;
      q <= 1'b0;
      q_x <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
      qual_cnt <= '0;
      mid_cnt <= '0;
      tgt <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sample_valid) begin
        mid_cnt <= '0;
        if (state == UNKNOWN) begin
          if (is_h || is_l) begin
            tgt <= is_h;
            qual_cnt <= run_n == CW'(DELAY) ? '0 : run_n;
            if (run_n == CW'(DELAY)) begin
              state <= is_h ? HIGH : LOW;
              q <= is_h;
              q_x <= 1'b0;
            end
          end else begin
            qual_cnt <= '0;
          end
        end else if (toward) begin
          qual_cnt <= qual_inc == CW'(DELAY) ? '0 : qual_inc;
          if (qual_inc == CW'(DELAY)) begin
            state <= is_h ? HIGH : LOW;
            q <= is_h;
            rise <= is_h;
            fall <= is_l;
          end
        end else begin
          qual_cnt <= '0;
          if (!hold) begin
            mid_cnt <= mid_inc == CW'(X_TIMEOUT) ? '0 : mid_inc;
            if (mid_inc == CW'(X_TIMEOUT)) begin
              state <= UNKNOWN;
              q_x <= 1'b1;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_logic_input_qualifier.sv
// tb_logic_input_qualifier: directed and randomized checks of logic_input_qualifier against a history-based reference model
module tb_logic_input_qualifier;
  localparam int W = 8, THH = 230, THL = 26, DELAY = 4, X_TIMEOUT = 16;
  logic clk = 1'b0, rst_n = 1'b0, sample_valid = 1'b0;
  logic [W-1:0] sample = '0;
  logic q, q_x, rise, fall;
  int n_checks = 0, n_fail = 0;
  int lvl;
  logic m_q, m_qx, m_rise, m_fall;
  int hist[$];
  logic [3:0] exp_v;
  logic [3:0] got_v;
  logic_input_qualifier #(.W(W), .THH(THH), .THL(THL), .DELAY(DELAY), .X_TIMEOUT(X_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .sample(sample), .sample_valid(sample_valid),
    .q(q), .q_x(q_x), .rise(rise), .fall(fall)
  );
  always #5 clk = ~clk;
  assign got_v = {q, q_x, rise, fall};
  assign exp_v = {m_q, m_qx, m_rise, m_fall};
  function automatic int cls(input int s);
    return s >= THH ? 2 : s <= THL ? 0 : 1;
  endfunction
  task automatic model(input int s, input logic v, input logic r);
    int c, n;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (!r) begin
      lvl = 0; m_q = 1'b0; m_qx = 1'b1; hist.delete();
      return;
    end
    if (!v) return;
    c = cls(s);
    hist.push_back(c);
    if (hist.size() > 64) void'(hist.pop_front());
    n = 0;
    for (int i = hist.size() - 1; i >= 0 && hist[i] == c; i--) n++;
    if (lvl == 0) begin
      if (c != 1 && n >= DELAY) begin
        lvl = c == 2 ? 2 : 1; m_q = (c == 2); m_qx = 1'b0; hist.delete();
      end
    end else if (c == 1) begin
      if (n >= X_TIMEOUT) begin
        lvl = 0; m_qx = 1'b1; hist.delete();
      end
    end else if (((lvl == 1 && c == 2) || (lvl == 2 && c == 0)) && n >= DELAY) begin
      m_rise = (c == 2); m_fall = (c == 0); m_q = (c == 2); lvl = c == 2 ? 2 : 1; hist.delete();
    end
  endtask
  task automatic step(input int s, input logic v, input logic r);
    sample = W'(s);
    sample_valid = v;
    rst_n = r;
    @(posedge clk);
    model(s, v, r);
    #1;
  endtask
  task automatic test_reset();
    step(255, 1'b1, 1'b0);
    step(255, 1'b1, 1'b0);
    n_checks++;
    if (got_v !== 4'b0100 || exp_v !== 4'b0100) begin
      n_fail++; $display("FAIL reset {q,q_x,rise,fall}: got %b want 0100", got_v);
    end
  endtask
  task automatic test_rise_from_unknown();
    for (int i = 0; i < 4; i++) begin
      step(255, 1'b1, 1'b1);
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL unknown_to_high sample %0d: got %b want %b", i + 1, got_v, exp_v);
      end
    end
    n_checks++;
    if (got_v !== 4'b1000) begin
      n_fail++; $display("FAIL unknown_to_high final: got %b want 1000", got_v);
    end
  endtask
  task automatic test_fall();
    int s[8] = '{0, 0, 0, 128, 0, 0, 0, 0};
    int pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(s[i], 1'b1, 1'b1);
      pulses += int'(fall);
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL high_to_low sample %0d: got %b want %b", i + 1, got_v, exp_v);
      end
    end
    n_checks++;
    if (pulses != 1 || got_v !== 4'b0001) begin
      n_fail++; $display("FAIL fall_once: got %0d pulses, final %b, want 1 pulse, final 0001", pulses, got_v);
    end
  endtask
  task automatic test_x_timeout();
    for (int i = 0; i < X_TIMEOUT; i++) begin
      step(128, 1'b1, 1'b1);
      n_checks++;
      if (got_v !== (i == X_TIMEOUT - 1 ? 4'b0100 : 4'b0000) || got_v !== exp_v) begin
        n_fail++; $display("FAIL x_timeout mid %0d: got %b model %b", i + 1, got_v, exp_v);
      end
    end
    for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b1);
    for (int i = 0; i < X_TIMEOUT - 1; i++) step(128, 1'b1, 1'b1);
    step(THL, 1'b1, 1'b1);
    n_checks++;
    if (got_v !== 4'b0000 || exp_v !== 4'b0000) begin
      n_fail++; $display("FAIL x_timeout_broken: got %b want 0000", got_v);
    end
  endtask
  task automatic test_thresholds();
    step(0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(THH - 1, 1'b1, 1'b1);
    n_checks++;
    if (got_v !== 4'b0100 || exp_v !== 4'b0100) begin
      n_fail++; $display("FAIL thh_minus_1: got %b want 0100", got_v);
    end
    for (int i = 0; i < 4; i++) step(THH, 1'b1, 1'b1);
    n_checks++;
    if (got_v !== 4'b1000 || exp_v !== 4'b1000) begin
      n_fail++; $display("FAIL thh_exact: got %b want 1000", got_v);
    end
    for (int i = 0; i < 4; i++) step(THL + 1, 1'b1, 1'b1);
    n_checks++;
    if (got_v !== 4'b1000 || exp_v !== 4'b1000) begin
      n_fail++; $display("FAIL thl_plus_1: got %b want 1000", got_v);
    end
    for (int i = 0; i < 4; i++) step(THL, 1'b1, 1'b1);
    n_checks++;
    if (got_v !== 4'b0001 || exp_v !== 4'b0001) begin
      n_fail++; $display("FAIL thl_exact: got %b want 0001", got_v);
    end
  endtask
  task automatic test_gap_and_reset();
    step(255, 1'b1, 1'b1);
    step(255, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(0, 1'b0, 1'b1);
      n_checks++;
      if (got_v !== 4'b0000) begin
        n_fail++; $display("FAIL gap_hold cycle %0d: got %b want 0000", i, got_v);
      end
    end
    step(255, 1'b1, 1'b1);
    n_checks++;
    if (got_v !== 4'b0000) begin
      n_fail++; $display("FAIL gap_3rd: got %b want 0000", got_v);
    end
    step(255, 1'b1, 1'b1);
    n_checks++;
    if (got_v !== 4'b1010 || exp_v !== 4'b1010) begin
      n_fail++; $display("FAIL gap_rise: got %b want 1010", got_v);
    end
    step(0, 1'b1, 1'b1);
    step(0, 1'b1, 1'b1);
    step(0, 1'b1, 1'b1);
    step(0, 1'b1, 1'b0);
    n_checks++;
    if (got_v !== 4'b0100) begin
      n_fail++; $display("FAIL reset_mid_run: got %b want 0100", got_v);
    end
    step(0, 1'b1, 1'b1);
    n_checks++;
    if (got_v !== 4'b0100 || exp_v !== 4'b0100) begin
      n_fail++; $display("FAIL reset_exit: got %b want 0100", got_v);
    end
  endtask
  task automatic test_random();
    int c = 1, s;
    logic v, r;
    logic prev_rise = 1'b0, prev_fall = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5, 0) == 0) c = $urandom_range(2, 0);
      s = c == 2 ? $urandom_range(255, THH) : c == 0 ? $urandom_range(THL, 0) : $urandom_range(THH - 1, THL + 1);
      v = $urandom_range(3, 0) != 0;
      r = $urandom_range(400, 0) != 0;
      step(s, v, r);
      n_checks++;
      if (got_v !== exp_v || (rise && fall) || (rise && prev_rise) || (fall && prev_fall)) begin
        n_fail++; $display("FAIL random cycle %0d: got %b want %b", i, got_v, exp_v);
      end
      prev_rise = rise;
      prev_fall = fall;
    end
  endtask
  initial begin
    lvl = 0; m_q = 1'b0; m_qx = 1'b1; m_rise = 1'b0; m_fall = 1'b0;
    test_reset();
    test_rise_from_unknown();
    test_fall();
    test_x_timeout();
    test_thresholds();
    test_gap_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
